sa3_operand_sequencer: RTL and testbench

Front-end sequencer for the 3×3 systolic convolution array. It receives the 9 filter bytes and 16 data bytes of one job over a byte stream with valid/ready flow control, and holds them as stable operand buses. It then drives `active_sa3` into the array, waits for `done_sa3`, captures the four 2×2 results, and returns them on a byte output stream. It is the initiator at the other end of the array's operand/result interface.

---
 rtl/sa3_operand_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_sa3_operand_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa3_operand_sequencer.sv
// sa3_operand_sequencer: byte-stream front end for the 3x3 systolic
// convolution array. Loads 9 filter + 16 data bytes, clears and runs the
// array, captures the four 2x2 results and streams them back out.
// Optional feature macro: SA3_SEQ_TIMEOUT_EN (RUN-phase watchdog, sticky err).
module sa3_operand_sequencer #(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic [127:0] a_flat,
    output logic [71:0]  b_flat,
    output logic         sa_clr,
    output logic         active_sa3,
    input  logic         done_sa3,
    input  logic [7:0]   c11,
    input  logic [7:0]   c12,
    input  logic [7:0]   c21,
    input  logic [7:0]   c22,
    output logic         out_valid,
    output logic [7:0]   out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {S_LOAD, S_CLR, S_RUN, S_DRAIN} state_t;

    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [1:0]     idx_q, idx_d;
    logic [127:0]   a_q, a_d;
    logic [71:0]    b_q, b_d;
    logic [31:0]    res_q, res_d;
    logic           in_ready_q, in_ready_d;
    logic           sa_clr_q, sa_clr_d;
    logic           active_q, active_d;
    logic           out_valid_q, out_valid_d;
    logic [7:0]     out_data_q, out_data_d;
    logic           busy_q, busy_d;

`ifdef SA3_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           err_q, err_d;
`else
    // TIMEOUT_CYCLES only has meaning when the watchdog is compiled in.
    if (TIMEOUT_CYCLES < 1) begin : g_unused_timeout
    end
`endif

    // Result byte i in delivery order c11, c12, c21, c22.
    function automatic logic [7:0] res_byte(input logic [31:0] r, input logic [1:0] i);
        return r[8*i +: 8];
    endfunction

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        in_ready_d  = in_ready_q;
        sa_clr_d    = 1'b0;
        active_d    = active_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
`ifdef SA3_SEQ_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    // Slots 0..8 are the filter, 9..24 the data tile.
                    for (int i = 0; i < 9; i++) begin
                        if (cnt_q == 5'(i)) b_d[8*i +: 8] = in_data;
                    end
                    for (int i = 0; i < 16; i++) begin
                        if (cnt_q == 5'(i + 9)) a_d[8*i +: 8] = in_data;
                    end
                    if (cnt_q == 5'd24) begin
                        state_d    = S_CLR;
                        cnt_d      = 5'd0;
                        in_ready_d = 1'b0;
                        sa_clr_d   = 1'b1;
                        busy_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            S_CLR: begin
                state_d  = S_RUN;
                active_d = 1'b1;
`ifdef SA3_SEQ_TIMEOUT_EN
                tmo_d    = '0;
`endif
            end
            S_RUN: begin
                if (done_sa3) begin
                    res_d       = {c22, c21, c12, c11};
                    active_d    = 1'b0;
                    state_d     = S_DRAIN;
                    idx_d       = 2'd0;
                    out_valid_d = 1'b1;
                    out_data_d  = c11;
                end
`ifdef SA3_SEQ_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Array never answered: abandon the job and flag it.
                    active_d   = 1'b0;
                    err_d      = 1'b1;
                    state_d    = S_LOAD;
                    cnt_d      = 5'd0;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (idx_q == 2'd3) begin
                        state_d     = S_LOAD;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        out_data_d = res_byte(res_q, idx_q + 2'd1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // State and registered outputs; reset returns everything to the idle LOAD state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOAD;
            cnt_q       <= 5'd0;
            idx_q       <= 2'd0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            sa_clr_q    <= 1'b0;
            active_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            busy_q      <= 1'b0;
`ifdef SA3_SEQ_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            sa_clr_q    <= sa_clr_d;
            active_q    <= active_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
`ifdef SA3_SEQ_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign a_flat     = a_q;
    assign b_flat     = b_q;
    assign sa_clr     = sa_clr_q;
    assign active_sa3 = active_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = busy_q;
`ifdef SA3_SEQ_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_sa3_operand_sequencer.sv
// Bench for sa3_operand_sequencer with a behavioural 3x3 array model
// (17-cycle run, accumulating results cleared by sa_clr) and a result scoreboard.
`timescale 1ns/1ps
module tb_sa3_operand_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'd0;
    logic         in_ready;
    logic [127:0] a_flat;
    logic [71:0]  b_flat;
    logic         sa_clr;
    logic         active_sa3;
    logic         done_sa3;
    logic [7:0]   c11, c12, c21, c22;
    logic         out_valid;
    logic [7:0]   out_data;
    logic         out_ready = 1'b1;
    logic         busy;
    logic         err;

    int total = 0;
    int bad = 0;
    logic [7:0]   sb[$];
    logic [7:0]   job[25];
    logic [127:0] exp_a;
    logic [71:0]  exp_b;
    logic         kill_done = 1'b0;
    int clr_total = 0;
    int act_total = 0;
    int clr0, act0;

    always #5 clk = ~clk;

    sa3_operand_sequencer #(.TIMEOUT_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .a_flat(a_flat), .b_flat(b_flat), .sa_clr(sa_clr), .active_sa3(active_sa3),
        .done_sa3(done_sa3), .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .err(err)
    );

    // Valid 2x2 convolution output (i,j) of the 4x4 tile with the 3x3 filter, 8-bit wrap.
    function automatic logic [7:0] conv(input logic [127:0] a, input logic [71:0] b,
                                        input int i, input int j);
        logic [7:0] s;
        s = 8'd0;
        for (int m = 0; m < 3; m++)
            for (int n = 0; n < 3; n++)
                s = s + a[8*((i+m)*4 + j + n) +: 8] * b[8*(m*3 + n) +: 8];
        return s;
    endfunction

    logic [7:0]  arr_cnt;
    logic [31:0] arr_acc;

    // Array model: accumulates one convolution per run, cleared by sa_clr or rst.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            arr_cnt <= 8'd0;
            arr_acc <= 32'd0;
        end else if (sa_clr) begin
            arr_cnt <= 8'd0;
            arr_acc <= 32'd0;
        end else if (active_sa3) begin
            if (arr_cnt != 8'hff) arr_cnt <= arr_cnt + 8'd1;
            if (arr_cnt == 8'd15)
                arr_acc <= {arr_acc[31:24] + conv(a_flat, b_flat, 1, 1),
                            arr_acc[23:16] + conv(a_flat, b_flat, 1, 0),
                            arr_acc[15:8]  + conv(a_flat, b_flat, 0, 1),
                            arr_acc[7:0]   + conv(a_flat, b_flat, 0, 0)};
        end else begin
            arr_cnt <= 8'd0;
        end
    end

    assign done_sa3 = active_sa3 && (arr_cnt == 8'd16) && !kill_done;
    assign c11 = arr_acc[7:0];
    assign c12 = arr_acc[15:8];
    assign c21 = arr_acc[23:16];
    assign c22 = arr_acc[31:24];

    // Cumulative pulse/cycle counters for sa_clr and active_sa3.
    always @(posedge clk) begin
        if (sa_clr) clr_total <= clr_total + 1;
        if (active_sa3) act_total <= act_total + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream job[] in (random gaps up to maxgap), optionally pushing expected results.
    task automatic load_job(input int maxgap, input bit push);
        int w;
        exp_a = '0;
        exp_b = '0;
        for (int i = 0; i < 9; i++) exp_b[8*i +: 8] = job[i];
        for (int i = 9; i < 25; i++) exp_a[8*(i-9) +: 8] = job[i];
        if (push) begin
            sb.push_back(conv(exp_a, exp_b, 0, 0));
            sb.push_back(conv(exp_a, exp_b, 0, 1));
            sb.push_back(conv(exp_a, exp_b, 1, 0));
            sb.push_back(conv(exp_a, exp_b, 1, 1));
        end
        clr0 = clr_total;
        act0 = act_total;
        for (int i = 0; i < 25; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, maxgap)) tick();
            in_valid = 1'b1;
            in_data  = job[i];
            w = 0;
            while (!in_ready && w < 100) begin tick(); w++; end
            tick();
        end
        in_valid = 1'b0;
        check("clr_pulse_high", {127'd0, sa_clr}, 128'd1);
        check("clr_busy", {127'd0, busy}, 128'd1);
        check("clr_in_ready", {127'd0, in_ready}, 128'd0);
        check("a_flat_loaded", a_flat, exp_a);
        check("b_flat_loaded", {56'd0, b_flat}, {56'd0, exp_b});
    endtask

    // Wait for results, optionally hold backpressure, then pop/compare four bytes.
    task automatic drain_job(input int hold);
        int w;
        w = 0;
        while (!out_valid && w < 200) begin tick(); w++; end
        if (!out_valid) begin
            check("out_valid_timeout", {127'd0, out_valid}, 128'd1);
            sb.delete();
            return;
        end
        check("first_out_latency", 128'(w), 128'd18);
        check("run_done_active_low", {127'd0, active_sa3}, 128'd0);
        if (hold > 0) begin
            out_ready = 1'b0;
            for (int h = 0; h < hold; h++) begin
                check("hold_valid", {127'd0, out_valid}, 128'd1);
                check("hold_data", {120'd0, out_data}, {120'd0, sb[0]});
                tick();
            end
            out_ready = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            logic [7:0] e;
            e = sb.pop_front();
            check("drain_valid", {127'd0, out_valid}, 128'd1);
            check("drain_data", {120'd0, out_data}, {120'd0, e});
            tick();
        end
        check("post_valid", {127'd0, out_valid}, 128'd0);
        check("post_in_ready", {127'd0, in_ready}, 128'd1);
        check("post_busy", {127'd0, busy}, 128'd0);
        check("operand_hold", a_flat, exp_a);
        check("clr_pulse_count", 128'(clr_total - clr0), 128'd1);
        check("active_cycles", 128'(act_total - act0), 128'd17);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_a_flat", a_flat, 128'd0);
        check("rst_b_flat", {56'd0, b_flat}, 128'd0);
        check("rst_sa_clr", {127'd0, sa_clr}, 128'd0);
        check("rst_active", {127'd0, active_sa3}, 128'd0);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out_data", {120'd0, out_data}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_err", {127'd0, err}, 128'd0);
        rst = 1'b0;
        tick();

        // All ones, then back-to-back repeat
        for (int i = 0; i < 25; i++) job[i] = 8'd1;
        load_job(0, 1'b1);
        drain_job(0);
        load_job(0, 1'b1);
        drain_job(0);

        // Centre tap with output backpressure
        for (int i = 0; i < 9; i++) job[i] = (i == 4) ? 8'd1 : 8'd0;
        for (int i = 9; i < 25; i++) job[i] = 8'(i - 8);
        load_job(0, 1'b1);
        check("centre_exp_c11", {120'd0, sb[0]}, 128'd6);
        check("centre_exp_c22", {120'd0, sb[3]}, 128'd11);
        drain_job(5);

        // All ones with random input gaps
        for (int i = 0; i < 25; i++) job[i] = 8'd1;
        load_job(3, 1'b1);
        check("gaps_exp_c11", {120'd0, sb[0]}, 128'd9);
        drain_job(0);

        // Random data, random gaps, short backpressure
        for (int i = 0; i < 25; i++) job[i] = 8'($urandom_range(0, 255));
        load_job(2, 1'b1);
        drain_job(2);

        // Reset on RUN cycle 5, then a clean centre-tap job
        for (int i = 0; i < 25; i++) job[i] = 8'd1;
        load_job(0, 1'b0);
        repeat (4) tick();
        check("midrun_active_before", {127'd0, active_sa3}, 128'd1);
        rst = 1'b1;
        #1;
        check("midrun_active", {127'd0, active_sa3}, 128'd0);
        check("midrun_busy", {127'd0, busy}, 128'd0);
        check("midrun_in_ready", {127'd0, in_ready}, 128'd1);
        check("midrun_a_flat", a_flat, 128'd0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) job[i] = (i == 4) ? 8'd1 : 8'd0;
        for (int i = 9; i < 25; i++) job[i] = 8'(i - 8);
        load_job(1, 1'b1);
        drain_job(0);

        // Array never completes
        kill_done = 1'b1;
        for (int i = 0; i < 25; i++) job[i] = 8'd1;
        load_job(0, 1'b0);
`ifdef SA3_SEQ_TIMEOUT_EN
        repeat (32) tick();
        check("tmo_still_active", {127'd0, active_sa3}, 128'd1);
        check("tmo_err_pending", {127'd0, err}, 128'd0);
        tick();
        check("tmo_active_dropped", {127'd0, active_sa3}, 128'd0);
        check("tmo_err_set", {127'd0, err}, 128'd1);
        check("tmo_in_ready", {127'd0, in_ready}, 128'd1);
        check("tmo_busy", {127'd0, busy}, 128'd0);
        check("tmo_no_out_valid", {127'd0, out_valid}, 128'd0);
        kill_done = 1'b0;
        load_job(0, 1'b1);
        drain_job(0);
        check("tmo_err_sticky", {127'd0, err}, 128'd1);
`else
        repeat (40) tick();
        check("notmo_active", {127'd0, active_sa3}, 128'd1);
        check("notmo_busy", {127'd0, busy}, 128'd1);
        check("notmo_err", {127'd0, err}, 128'd0);
        check("notmo_no_out_valid", {127'd0, out_valid}, 128'd0);
        kill_done = 1'b0;
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("final_err_cleared", {127'd0, err}, 128'd0);
        check("final_in_ready", {127'd0, in_ready}, 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
